// File: rtl/seq_detector_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_detector_frame_ctrl_if
// Handshake bundle between a word producer, the frame controller and the
// result consumer.
//   in_valid / in_ready   : frame handshake (producer -> controller)
//   in_data               : frame word, MSB is processed first
//   pattern               : target pattern, MSB must match the earliest bit
//   overlap_en            : 1 = overlapping, 0 = non-overlapping detection
//   out_valid / out_ready : result handshake (controller -> consumer)
//   match_cnt             : number of matches in the frame
//   match_map             : bit j set when a match completed on in_data bit j
//   busy                  : controller is working on or holding a frame
// The slave modport is the controller's view; master is the environment's.
// -----------------------------------------------------------------------------
interface seq_detector_frame_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PAT_W-1:0]  pattern;
  logic              overlap_en;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  match_cnt;
  logic [DATA_W-1:0] match_map;
  logic              busy;

  modport master (
    output in_valid, in_data, pattern, overlap_en, out_ready,
    input  in_ready, out_valid, match_cnt, match_map, busy
  );

  modport slave (
    input  in_valid, in_data, pattern, overlap_en, out_ready,
    output in_ready, out_valid, match_cnt, match_map, busy
  );
endinterface

// File: rtl/seq_detector_frame_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detector_frame_ctrl
// Accepts one DATA_W-bit frame per handshake, serialises it MSB first through
// a PAT_W-bit Mealy pattern detector (overlapping or non-overlapping per
// frame) and returns the match count and per-bit match map on a second
// handshake.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of seq_detector_frame_ctrl_if (both handshakes,
//           frame data, pattern, mode, results and busy)
// -----------------------------------------------------------------------------
module seq_detector_frame_ctrl #(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  seq_detector_frame_ctrl_if.slave bus
);

  localparam int IDX_W  = $clog2(DATA_W);
  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] map_q;
  logic [DATA_W-1:0] frame_q;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic [PAT_W-2:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  logic [IDX_W-1:0]  idx_q;

  logic [IDX_W-1:0]  pos_s;
  logic [PAT_W-1:0]  window_s;
  logic              hit_s;

  // Detector window for the bit being processed this cycle and its match flag.
  always_comb begin
    pos_s    = LAST_IDX - idx_q;
    window_s = {hist_q, frame_q[pos_s]};
    // A window only counts once PAT_W-1 valid history bits precede it.
    if ((state_q == S_SHIFT) && (fill_q == FILL_FULL) && (window_s == pat_q)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Frame sequencer: acceptance, bit-serial detection and result hand-off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      map_q       <= '0;
      frame_q     <= '0;
      pat_q       <= '0;
      ovl_q       <= 1'b0;
      hist_q      <= '0;
      fill_q      <= '0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            frame_q    <= bus.in_data;
            pat_q      <= bus.pattern;
            ovl_q      <= bus.overlap_en;
            hist_q     <= '0;
            fill_q     <= '0;
            cnt_q      <= '0;
            map_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_SHIFT;
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (hit_s) begin
            cnt_q        <= cnt_q + CNT_W'(1);
            map_q[pos_s] <= 1'b1;
          end
          // Non-overlapping: a match consumes its bits, so restart the window.
          if (hit_s && !ovl_q) begin
            hist_q <= '0;
            fill_q <= '0;
          end else begin
            hist_q <= window_s[PAT_W-2:0];
            if (fill_q != FILL_FULL) begin
              fill_q <= fill_q + FILL_W'(1);
            end
          end
          if (idx_q == LAST_IDX) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // in_ready must read low during the reset cycle itself, before the edge
  // clears the register.
  assign bus.in_ready  = in_ready_q & ~reset;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.match_cnt = cnt_q;
  assign bus.match_map = map_q;

endmodule

// File: tb/tb_seq_detector_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_frame_ctrl
// Directed scenarios followed by randomized traffic. A frame-level reference
// model scans the whole word for pattern occurrences; a handshake timing model
// predicts in_ready/out_valid/busy. Outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_seq_detector_frame_ctrl;
  localparam int DW = 16;
  localparam int PW = 4;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detector_frame_ctrl_if #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW)) bus ();

  seq_detector_frame_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state
  bit          m_live     = 1'b0;
  bit          m_ready    = 1'b0;
  bit          m_inflight = 1'b0;
  bit          m_valid    = 1'b0;
  int          m_left     = 0;
  int          m_cnt      = 0;
  logic [DW-1:0] m_map    = '0;
  int          p_cnt      = 0;
  logic [DW-1:0] p_map    = '0;
  int          acc_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole-frame reference: slide over every PW-bit window in processing order.
  function automatic void ref_frame(input logic [DW-1:0] d, input logic [PW-1:0] p,
                                    input logic ov, output int cnt, output logic [DW-1:0] map);
    int nxt;
    int s;
    bit eq;
    logic [DW-1:0] ds;
    logic [PW-1:0] ps;
    cnt = 0;
    map = '0;
    nxt = 0;
    for (int i = PW - 1; i < DW; i++) begin
      s  = i - PW + 1;
      eq = 1'b1;
      for (int k = 0; k < PW; k++) begin
        ds = d << (s + k);
        ps = p << k;
        if (ds[DW-1] !== ps[PW-1]) eq = 1'b0;
      end
      if (eq && (ov || s >= nxt)) begin
        cnt++;
        map = map | (DW'(1) << (DW - 1 - i));
        nxt = i + 1;
      end
    end
  endfunction

  // Compare outputs, then advance the model with the inputs the next edge sees.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_ready && !reset));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("busy", 32'(bus.busy), 32'(m_inflight));
      if (!m_inflight || m_valid) begin
        chk("match_cnt", 32'(bus.match_cnt), m_cnt);
        chk("match_map", 32'(bus.match_map), 32'(m_map));
      end
    end
    cyc++;
    if (reset) begin
      m_live = 1'b1; m_ready = 1'b0; m_inflight = 1'b0; m_valid = 1'b0;
      m_cnt = 0; m_map = '0;
    end else if (m_live) begin
      if (m_valid) begin
        if (bus.out_ready) begin
          m_valid = 1'b0; m_inflight = 1'b0; m_ready = 1'b1;
        end
      end else if (m_inflight) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1'b1; m_cnt = p_cnt; m_map = p_map;
        end
      end else if (bus.in_valid && m_ready) begin
        m_inflight = 1'b1; m_ready = 1'b0; m_left = DW;
        ref_frame(bus.in_data, bus.pattern, bus.overlap_en, p_cnt, p_map);
        acc_cyc.push_back(cyc);
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic ov);
    logic rdy;
    bit done = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.pattern = p; bus.overlap_en = ov;
    for (int k = 0; k < 100 && !done; k++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("take_drop", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int c;
    logic [DW-1:0] mp;
    int lat;
    int a0;
    int got;
    int res[2];
    logic rdy;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.pattern = '0;
    bus.overlap_en = 1'b0; bus.out_ready = 1'b0;

    // Pin the reference model with hand-derived results.
    ref_frame(16'h6C00, 4'b0110, 1'b1, c, mp);
    chk("ref_ovl_cnt", c, 32'd2);  chk("ref_ovl_map", 32'(mp), 32'h1200);
    ref_frame(16'h6C00, 4'b0110, 1'b0, c, mp);
    chk("ref_novl_cnt", c, 32'd1); chk("ref_novl_map", 32'(mp), 32'h1000);
    ref_frame(16'hFFFF, 4'b1111, 1'b1, c, mp);
    chk("ref_ones_ovl_cnt", c, 32'd13); chk("ref_ones_ovl_map", 32'(mp), 32'h1FFF);
    ref_frame(16'hFFFF, 4'b1111, 1'b0, c, mp);
    chk("ref_ones_novl_cnt", c, 32'd4); chk("ref_ones_novl_map", 32'(mp), 32'h1111);

    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
    chk("rst_map", 32'(bus.match_map), 32'd0);
    reset = 1'b0;

    // 1: overlapping 0110
    send(16'h6C00, 4'b0110, 1'b1);
    wait_result(lat);
    chk("t1_latency", lat, 32'd16);
    chk("t1_cnt", 32'(bus.match_cnt), 32'd2);
    chk("t1_map", 32'(bus.match_map), 32'h1200);
    take();

    // 2: non-overlapping 0110
    send(16'h6C00, 4'b0110, 1'b0);
    wait_result(lat);
    chk("t2_cnt", 32'(bus.match_cnt), 32'd1);
    chk("t2_map", 32'(bus.match_map), 32'h1000);
    take();

    // 3: runs of ones
    send(16'hFFFF, 4'b1111, 1'b1);
    wait_result(lat);
    chk("t3o_cnt", 32'(bus.match_cnt), 32'd13);
    chk("t3o_map", 32'(bus.match_map), 32'h1FFF);
    take();
    send(16'hFFFF, 4'b1111, 1'b0);
    wait_result(lat);
    chk("t3n_cnt", 32'(bus.match_cnt), 32'd4);
    chk("t3n_map", 32'(bus.match_map), 32'h1111);
    take();

    // 4: back-pressure with a second frame waiting
    send(16'h6C00, 4'b0110, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = 16'h0000; bus.pattern = 4'b0110; bus.overlap_en = 1'b0;
    wait_result(lat);
    chk("t4_latency", lat, 32'd16);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_cnt", 32'(bus.match_cnt), 32'd2);
      chk("t4_hold_map", 32'(bus.match_map), 32'h1200);
      chk("t4_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t4_ready_after", 32'(bus.in_ready), 32'd1);
    chk("t4_busy_after", 32'(bus.busy), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_second_accepted", 32'(bus.busy), 32'd1);
    wait_result(lat);
    chk("t4b_latency", lat, 32'd16);
    chk("t4b_cnt", 32'(bus.match_cnt), 32'd0);
    chk("t4b_map", 32'(bus.match_map), 32'd0);
    take();

    // 5: reset mid-frame
    send(16'hA5A5, 4'b0101, 1'b1);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_cnt", 32'(bus.match_cnt), 32'd0);
    chk("t5_map", 32'(bus.match_map), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    chk("t5_ready_high", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t5_no_valid", 32'(bus.out_valid), 32'd0);
    end
    send(16'h6C00, 4'b0110, 1'b1);
    wait_result(lat);
    chk("t5_new_cnt", 32'(bus.match_cnt), 32'd2);
    take();

    // 6: back-to-back frames, consumer always ready
    bus.out_ready = 1'b1;
    a0 = acc_cyc.size();
    send(16'hFFFF, 4'b1111, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = 16'h6C00; bus.pattern = 4'b1111; bus.overlap_en = 1'b1;
    got = 0;
    res[0] = -1; res[1] = -1;
    for (int k = 0; k < 80 && got < 2; k++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy && bus.in_valid) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        res[got] = int'(bus.match_cnt);
        got++;
      end
    end
    bus.in_valid = 1'b0;
    chk("t6_results", got, 32'd2);
    chk("t6_first_cnt", res[0], 32'd13);
    chk("t6_second_cnt", res[1], 32'd0);
    chk("t6_accepts", acc_cyc.size() - a0, 32'd2);
    if (acc_cyc.size() >= a0 + 2) chk("t6_period", acc_cyc[a0+1] - acc_cyc[a0], 32'd18);
    tick();
    bus.out_ready = 1'b0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      reset          = ($urandom_range(0, 299) == 0);
      bus.in_valid   = ($urandom_range(0, 2) != 0);
      bus.pattern    = PW'($urandom);
      bus.overlap_en = 1'($urandom);
      if ($urandom_range(0, 3) == 0) bus.in_data = {4{bus.pattern}} ^ DW'(1 << $urandom_range(0, DW - 1));
      else bus.in_data = DW'($urandom);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (25) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_detector_frame_ctrl.md
Name: seq_detector_frame_ctrl

Overview:
Frame-level controller that sequences a programmable pattern Mealy detector over parallel data words.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Serialises the word MSB first, one bit per clock, through an embedded PAT_W-bit pattern detector.
- Supports overlapping and non-overlapping modes, selected per frame.
- Returns the match count and a per-bit match map through a second valid/ready handshake.
- Sits between a word-oriented producer and downstream consumers that need detection results per frame, not per bit.

Parameters:
DATA_W, 16, frame width in bits (≥ PAT_W).
PAT_W, 4, pattern length in bits (2..8).
CNT_W, 5, match counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer has a frame
in_ready  output  1  controller can accept a frame
in_data  input  DATA_W  frame; bit DATA_W-1 is processed first
pattern  input  PAT_W  target pattern; bit PAT_W-1 must match the earliest bit
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
out_valid  output  1  result available
out_ready  input  1  consumer takes the result
match_cnt  output  CNT_W  number of matches in the frame
match_map  output  DATA_W  bit j = 1 if a match completed on in_data bit j
busy  output  1  high in SHIFT or DONE

Behaviour:
Clock and reset:
- One clock: clk. Reset is synchronous and active-high.
- While reset is high, the next edge forces: state IDLE, in_ready=0, out_valid=0, busy=0, match_cnt=0, match_map=0. History, fill count and bit index are also cleared.
- in_ready is gated low while reset is high. in_valid is ignored during reset.

States:
IDLE:
- in_ready=1.
- On in_valid && in_ready at edge E0: latch in_data, pattern and overlap_en; clear history, fill, count and map; bit index i=0; go to SHIFT.
- Input changes after E0 have no effect on the frame.

SHIFT (in_ready=0, busy=1), one bit per edge:
- At edge E(i+1), bit b = frame[DATA_W-1-i] is processed.
- Combinational window = {history[PAT_W-2:0], b}.
- A match occurs when window == latched pattern and fill ≥ PAT_W-1.
- On a match: count += 1 and map[DATA_W-1-i] = 1.
- Overlapping mode: history always shifts in b, and fill saturates at PAT_W-1.
- Non-overlapping mode: after a match, history and fill clear to 0, so the next match needs PAT_W fresh bits.
- No match: history shifts in b and fill increments (saturating).
- After the bit with i = DATA_W-1 is processed (edge E(DATA_W)), go to DONE.

DONE:
- out_valid=1 with match_cnt and match_map stable.
- Go to IDLE on the edge where out_valid && out_ready. out_valid drops and in_ready rises after that edge.
- out_ready held low: results hold indefinitely.

Timing and frame rules:
- Latency: out_valid first high after edge E(DATA_W), i.e. DATA_W cycles after the acceptance edge.
- Minimum frame period: DATA_W+2 cycles.
- No matches span frames: history and fill are cleared at every acceptance.
- match_cnt and match_map hold their last values in IDLE until the next acceptance clears them.
- Reset mid-SHIFT or mid-DONE aborts the frame. No out_valid is produced for it.
- in_valid while busy: no acceptance, and the producer must hold.
- Count cannot overflow, since max matches = DATA_W-PAT_W+1 < 2^CNT_W.

Test Plan:
1. Overlap 0110: reset 2 cycles, then pattern=4'b0110, overlap_en=1, in_data=16'h6C00. Required: out_valid exactly 16 cycles after acceptance, match_cnt=2, match_map=16'h1200.
2. Non-overlap 0110: same frame with overlap_en=0. Required: match_cnt=1, match_map=16'h1000.
3. Runs of ones: pattern=4'b1111, in_data=16'hFFFF. Required: overlap_en=1 gives cnt=13, map=16'h1FFF; overlap_en=0 gives cnt=4, map=16'h1111.
4. Back-pressure: out_ready low for 5 cycles in DONE, and in_valid high with a new frame during SHIFT/DONE. Required:
   - outputs stable and out_valid held;
   - in_ready=0 throughout, with the second frame accepted only the cycle after the out handshake;
   - the second frame (pattern=4'b0110, in_data=16'h0000) gives cnt=0, map=0, proving state was cleared.
5. Reset mid-frame: accept a frame, assert reset at SHIFT bit 7 for 1 cycle. Required:
   - all outputs 0 the next cycle and no out_valid for the aborted frame;
   - in_ready=1 the cycle after reset deasserts;
   - a new 16'h6C00/0110/overlap frame then yields cnt=2.
6. Back-to-back frames with out_ready tied high: frames 16'hFFFF then 16'h6C00, pattern 4'b1111. Required:
   - frame period 18 cycles;
   - first result cnt=13, second cnt=0, so no carry-over of history between frames.
